data_memory: RTL and testbench
==============================

# data_memory

Responder side of the core's data memory interface. It is a synchronous word-organised RAM serving `riscv_core`'s `data_rd_*` and `data_wr*` ports, with byte, halfword and word writes. It also decodes a small MMIO window: a free-running cycle counter, a console transmit FIFO drained through a valid/ready byte stream, and a status register. It sits beside the core in the top-level system, opposite the instruction memory.

## Interface
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; byte address range is `0 .. 4*DEPTH_WORDS-1`.
- `FIFO_DEPTH`, default 8: console FIFO entries; must be a power of two.
- `MMIO_BASE`, default 32'hFFFF_0000: base of the MMIO window, which is 16 bytes, word aligned.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_rd_addr` in 32: byte read address; the block always reads.
- `data_rd_data` out 32: aligned word at `{data_rd_addr[31:2],2'b00}`, registered.
- `data_wr` in 2: write size, encoded as 00 none, 01 byte, 10 halfword, 11 word.
- `data_wr_addr` in 32: byte write address.
- `data_wr_data` in 32: write data, right-aligned (byte in [7:0], halfword in [15:0]).
- `con_valid` out 1: console FIFO is non-empty.
- `con_data` out 8: FIFO head byte.
- `con_ready` in 1: consumer accepts the head byte.
- `err_misaligned` out 1: sticky flag, set by a misaligned write.

## Operation
- **RAM writes.** When `data_wr != 0` and the address is in the RAM range, the selected lanes of word `data_wr_addr[31:2]` are updated.
  - Byte: lane `addr[1:0]` gets `data_wr_data[7:0]`.
  - Halfword: lanes `{addr[1],0}` and `{addr[1],1}` get `data_wr_data[15:0]`, little-endian.
  - Word: all four lanes.
  - Untouched lanes keep their value.
- **Misaligned writes.** A halfword with `addr[0]=1`, or a word with `addr[1:0]!=0`, writes nothing anywhere and sets `err_misaligned`. The flag clears only on reset.
- **Out-of-range writes.** A write outside both the RAM range and the MMIO window is dropped silently.
- **Reads.** `data_rd_data` is registered each cycle.
  - In the RAM range: the RAM word.
  - At MMIO addresses: the MMIO value.
  - Anywhere else: 0.
- **Same word read and written in one cycle.** The read returns the pre-write contents (read-first).
- **MMIO map** (word-aligned; byte and halfword accesses use the word):
  - Base+0: `cycle` counter, 32-bit, +1 every cycle, wraps from 0xFFFF_FFFF to 0. Read-only; writes are ignored.
  - Base+4: console.
    - Write of any size pushes `data_wr_data[7:0]`.
    - Read returns `{24'b0, count}`, where `count` is the number of FIFO entries (zero-extended).
  - Base+8: status, read-only, `{29'b0, overflow, err_misaligned, full}`.
  - Base+12: reserved. Reads return 0; writes are ignored.
- **Console FIFO.**
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the byte is dropped and the sticky `overflow` bit is set.
  - Pop happens when `con_valid && con_ready`.
  - Simultaneous push and pop on an empty FIFO: the push is stored, and nothing is popped because `con_valid` was 0.
  - Read and write pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally.
- **Misaligned console writes.** A misaligned write into the MMIO window also sets `err_misaligned` and is dropped.

## Timing
- **Read latency.** 1 cycle: the address presented in cycle N is valid on `data_rd_data` in cycle N+1.
- **Write visibility.** A write in cycle N is committed at the edge ending N, so a read addressed in N+1 sees it.
- **Console output.** A push in cycle N makes `con_valid` go high in N+1. `con_data` is combinational from the FIFO head.
- **Counter read.** A read of `cycle` addressed in cycle N returns the counter value sampled at the edge ending N.
- **Reset values** (asynchronous, on `rst_n` low):
  - `data_rd_data`=0, `cycle`=0, FIFO empty (`con_valid`=0, `con_data`=0), `overflow`=0, `err_misaligned`=0.
  - RAM contents are not reset.
- **Reset mid-operation.** Pending FIFO bytes are discarded. Writes in the reset-release cycle are not performed, because `rst_n` must be high at the edge.

## Test plan
- **Store/load widths.** Word write 0x11223344 @0x10; byte write 0xAA @0x11; halfword write 0xBEEF @0x12; read @0x10 → 0xBEEFAA44 one cycle later.
- **Read-first.** Same-cycle read and write of word @0x20 (old 0x0, new 0x5): `data_rd_data`=0x0; next-cycle read → 0x5.
- **Misaligned and out-of-range.** Halfword write @0x3 → RAM unchanged, `err_misaligned`=1. Read @4*DEPTH_WORDS → 0.
- **Console stream.** Push 'H','i' with `con_ready`=0, then raise `con_ready` → 0x48 then 0x69 accepted in consecutive cycles, then `con_valid`=0. Console read mid-way returns count 2, then 1.
- **FIFO overflow.**
  - Push 9 bytes with `con_ready`=0 → 9th dropped, status=0b101.
  - Push while full with `con_ready`=1 → accepted, status full bit stays 1.
- **Counter and reset.** Read base+0 at two addresses 5 cycles apart → difference 5. Assert `rst_n` low mid-drain → `con_valid`=0 and `data_rd_data`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/data_memory.sv
// Data memory responder: word-organised RAM with byte/halfword/word writes,
// plus an MMIO window holding a cycle counter, a console TX FIFO and status.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_rd_addr,
  output logic [31:0] data_rd_data,
  input  logic [1:0]  data_wr,
  input  logic [31:0] data_wr_addr,
  input  logic [31:0] data_wr_data,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        err_misaligned
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [29:0] RAM_WORDS  = 30'(DEPTH_WORDS);
  localparam logic [27:0] MMIO_TAG   = MMIO_BASE[31:4];
  localparam logic [PW:0] FIFO_LIMIT = (PW + 1)'(FIFO_DEPTH);

  logic [31:0] mem      [DEPTH_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [PW:0]   wr_ptr, rd_ptr, fifo_count;
  logic [31:0]   cycle;
  logic          overflow;
  logic          fifo_empty, fifo_full, pop, push_req, push_ok;
  logic          wr_active, wr_misaligned, wr_in_ram, wr_in_mmio, ram_we;
  logic          rd_in_ram, rd_in_mmio;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lanes, rd_next;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          unused_rd_lsbs;

  assign unused_rd_lsbs = ^data_rd_addr[1:0];

  assign wr_active     = (data_wr != 2'b00);
  assign wr_misaligned = wr_active &&
                         (((data_wr == 2'b10) && data_wr_addr[0]) ||
                          ((data_wr == 2'b11) && (data_wr_addr[1:0] != 2'b00)));
  assign wr_in_ram     = (data_wr_addr[31:2] < RAM_WORDS);
  assign wr_in_mmio    = (data_wr_addr[31:4] == MMIO_TAG);
  assign rd_in_ram     = (data_rd_addr[31:2] < RAM_WORDS);
  assign rd_in_mmio    = (data_rd_addr[31:4] == MMIO_TAG);
  assign wr_idx        = data_wr_addr[AW+1:2];
  assign rd_idx        = data_rd_addr[AW+1:2];

  // rst_n gates the RAM so a write presented while in reset never lands
  assign ram_we = rst_n && wr_active && !wr_misaligned && wr_in_ram;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_LIMIT);
  assign con_valid  = !fifo_empty;
  assign con_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PW-1:0]];
  assign pop        = con_valid && con_ready;
  assign push_req   = wr_active && !wr_misaligned && wr_in_mmio &&
                      (data_wr_addr[3:2] == 2'b01);
  assign push_ok    = push_req && (!fifo_full || pop);

  // Lane enables and data replicated so every enabled lane sees its byte
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = data_wr_data;
    case (data_wr)
      2'b01: begin
        wr_be    = 4'b0001 << data_wr_addr[1:0];
        wr_lanes = {4{data_wr_data[7:0]}};
      end
      2'b10: begin
        wr_be    = data_wr_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{data_wr_data[15:0]}};
      end
      2'b11:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  always_comb begin
    rd_next = '0;
    if (rd_in_ram) begin
      rd_next = mem[rd_idx];
    end else if (rd_in_mmio) begin
      case (data_rd_addr[3:2])
        2'd0:    rd_next = cycle;
        2'd1:    rd_next = 32'(fifo_count);
        2'd2:    rd_next = {29'b0, overflow, err_misaligned, fifo_full};
        default: rd_next = '0;
      endcase
    end
  end

  // RAM contents are deliberately not reset; reads sample old data (read-first)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && wr_be[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr[PW-1:0]] <= data_wr_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rd_data   <= '0;
      cycle          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow       <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      data_rd_data <= rd_next;
      cycle        <= cycle + 32'd1;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
      if (wr_misaligned) begin
        err_misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios then random traffic
// compared against a word-array / byte-queue reference model.
module tb_data_memory;

  localparam int          DEPTH = 1024;
  localparam int          FD    = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] OOR   = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_rd_addr = '0;
  logic [31:0] data_rd_data;
  logic [1:0]  data_wr = '0;
  logic [31:0] data_wr_addr = '0;
  logic [31:0] data_wr_data = '0;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic        err_misaligned;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  ref_q [$];
  logic [31:0] ref_cycle = '0;
  bit          ref_ovf = 1'b0;
  bit          ref_err = 1'b0;

  data_memory #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_rd_addr(data_rd_addr),
    .data_rd_data(data_rd_data),
    .data_wr(data_wr),
    .data_wr_addr(data_wr_addr),
    .data_wr_data(data_wr_data),
    .con_valid(con_valid),
    .con_data(con_data),
    .con_ready(con_ready),
    .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a < 32'(4 * DEPTH)) return ref_mem[a >> 2];
    if ((a & 32'hFFFF_FFF0) == BASE) begin
      case (a & 32'hC)
        32'h0:   return ref_cycle;
        32'h4:   return 32'(ref_q.size());
        32'h8:   return {29'b0, ref_ovf, ref_err, ref_q.size() == FD};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic void modelReset();
    ref_q.delete();
    ref_cycle = '0;
    ref_ovf   = 1'b0;
    ref_err   = 1'b0;
  endfunction

  // One clock of traffic: drive, predict, clock, then compare all outputs
  task automatic applyStimulus(input logic [1:0] wr, input logic [31:0] wa, input logic [31:0] wd,
                               input logic [31:0] ra, input logic rdy);
    logic [31:0] exp_rd;
    bit          pop;
    int          nbytes;
    longint      mask;
    data_wr = wr; data_wr_addr = wa; data_wr_data = wd;
    data_rd_addr = ra; con_ready = rdy;
    exp_rd = modelRead(ra);
    pop = (ref_q.size() != 0) && rdy;
    if (pop) void'(ref_q.pop_front());
    if (wr != 2'b00) begin
      if ((wr == 2'b10 && wa[0]) || (wr == 2'b11 && wa[1:0] != 2'b00)) begin
        ref_err = 1'b1;
      end else if (wa < 32'(4 * DEPTH)) begin
        nbytes = (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
        mask = ((64'd1 << (8 * nbytes)) - 1) << (8 * (wa % 4));
        ref_mem[wa >> 2] = 32'((longint'(ref_mem[wa >> 2]) & ~mask) |
                               ((longint'(wd) << (8 * (wa % 4))) & mask));
      end else if ((wa & 32'hFFFF_FFFC) == BASE + 32'd4) begin
        if (ref_q.size() < FD) ref_q.push_back(wd[7:0]);
        else ref_ovf = 1'b1;
      end
    end
    ref_cycle = ref_cycle + 32'd1;
    @(posedge clk);
    #1;
    checkOutput("rd_data", data_rd_data, exp_rd);
    checkOutput("con_valid", 32'(con_valid), 32'(ref_q.size() != 0));
    if (ref_q.size() != 0) checkOutput("con_data", 32'(con_data), 32'(ref_q[0]));
    checkOutput("err_misaligned", 32'(err_misaligned), 32'(ref_err));
  endtask

  task automatic idle(input logic [31:0] ra, input logic rdy);
    applyStimulus(2'b00, 32'h0, 32'h0, ra, rdy);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'($urandom_range(0, 255));
      3, 4:    return BASE + 32'($urandom_range(0, 15));
      default: return 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
    endcase
  endfunction

  logic [31:0] c0, c1;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rd_data", data_rd_data, 32'h0);
    checkOutput("reset con_valid", 32'(con_valid), 32'h0);
    checkOutput("reset con_data", 32'(con_data), 32'h0);
    checkOutput("reset err", 32'(err_misaligned), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) applyStimulus(2'b11, 32'(4 * i), 32'h0, OOR, 1'b0);

    // Store/load widths
    applyStimulus(2'b11, 32'h10, 32'h1122_3344, OOR, 1'b0);
    applyStimulus(2'b01, 32'h11, 32'h0000_00AA, OOR, 1'b0);
    applyStimulus(2'b10, 32'h12, 32'h0000_BEEF, 32'h10, 1'b0);
    idle(32'h10, 1'b0);
    checkOutput("widths", data_rd_data, 32'hBEEF_AA44);

    // Read-first
    applyStimulus(2'b11, 32'h20, 32'h5, 32'h20, 1'b0);
    checkOutput("read-first old", data_rd_data, 32'h0);
    idle(32'h20, 1'b0);
    checkOutput("read-first new", data_rd_data, 32'h5);

    // Console stream
    applyStimulus(2'b01, BASE + 32'd4, 32'h48, OOR, 1'b0);
    applyStimulus(2'b01, BASE + 32'd4, 32'h69, OOR, 1'b0);
    checkOutput("con head H", 32'(con_data), 32'h48);
    idle(BASE + 32'd4, 1'b1);
    checkOutput("con count 2", data_rd_data, 32'd2);
    checkOutput("con head i", 32'(con_data), 32'h69);
    idle(BASE + 32'd4, 1'b1);
    checkOutput("con count 1", data_rd_data, 32'd1);
    checkOutput("con drained", 32'(con_valid), 32'h0);

    // FIFO overflow
    for (int i = 0; i < 9; i++) applyStimulus(2'b01, BASE + 32'd4, 32'(8'h30 + i), OOR, 1'b0);
    idle(BASE + 32'd8, 1'b0);
    checkOutput("status ovf", data_rd_data, 32'b101);
    applyStimulus(2'b11, BASE + 32'd4, 32'h7A, BASE + 32'd4, 1'b1);
    checkOutput("full count", data_rd_data, 32'd8);
    idle(BASE + 32'd8, 1'b0);
    checkOutput("status full kept", data_rd_data, 32'b101);
    for (int i = 0; i < FD; i++) idle(OOR, 1'b1);
    checkOutput("fifo empty", 32'(con_valid), 32'h0);

    // Misaligned and out-of-range
    applyStimulus(2'b10, 32'h3, 32'h1234, OOR, 1'b0);
    idle(32'h0, 1'b0);
    checkOutput("misaligned ram", data_rd_data, 32'h0);
    checkOutput("misaligned flag", 32'(err_misaligned), 32'h1);
    idle(32'(4 * DEPTH), 1'b0);
    checkOutput("out of range", data_rd_data, 32'h0);

    // Counter
    idle(BASE, 1'b0);
    c0 = data_rd_data;
    repeat (4) idle(OOR, 1'b0);
    idle(BASE, 1'b0);
    c1 = data_rd_data;
    checkOutput("cycle diff", c1 - c0, 32'd5);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, BASE + 32'd4, 32'(8'h61 + i), OOR, 1'b0);
    idle(32'h10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async con_valid", 32'(con_valid), 32'h0);
    checkOutput("async rd_data", data_rd_data, 32'h0);
    checkOutput("async err", 32'(err_misaligned), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(BASE, 1'b0);
    checkOutput("cycle after reset", data_rd_data, 32'h0);
    idle(32'h10, 1'b0);
    checkOutput("ram kept", data_rd_data, 32'hBEEF_AA44);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), randAddr(), $urandom, randAddr(),
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
